// File: rtl/svc_queue.sv
// -----------------------------------------------------------------------------
// svc_queue
//
// Multi-channel customer queue. Holds NCH independent circular FIFOs (one per
// service type), stamps every accepted entry with a global ticket number and
// presents exactly one head entry at a time to the dispatcher over a
// valid/ready handshake. Dequeue is first-word-fall-through.
//
// Configuration macro:
//   SVC_QUEUE_STRICT_PRIO_EN  defined   -> lowest-index non-empty channel wins
//                             undefined -> round-robin starting after the
//                                          last served channel
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   enq_valid/ch/data  enqueue request, target channel, payload
//   enq_ready       target channel exists and is not full (combinational)
//   enq_tkt         ticket that an accept in this cycle will receive
//   deq_valid/ready handshake with the dispatcher
//   deq_ch/data/tkt presented entry (zero while deq_valid is low)
//   full, empty     per-channel status bits
//   count           per-channel occupancy, channel k at [(k+1)*CNT_W-1 -: CNT_W]
//   drop_cnt        rejected enqueue attempts, saturating
// -----------------------------------------------------------------------------
module svc_queue #(
    parameter int NCH    = 4,
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8,
    parameter int TKT_W  = 8,
    parameter int CH_W   = (NCH == 1) ? 1 : $clog2(NCH),
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enq_valid,
    input  logic [CH_W-1:0]        enq_ch,
    input  logic [DATA_W-1:0]      enq_data,
    output logic                   enq_ready,
    output logic [TKT_W-1:0]       enq_tkt,
    output logic                   deq_valid,
    input  logic                   deq_ready,
    output logic [CH_W-1:0]        deq_ch,
    output logic [DATA_W-1:0]      deq_data,
    output logic [TKT_W-1:0]       deq_tkt,
    output logic [NCH-1:0]         full,
    output logic [NCH-1:0]         empty,
    output logic [NCH*CNT_W-1:0]   count,
    output logic [15:0]            drop_cnt
);

    localparam int PTR_W = (DEPTH == 1) ? 1 : $clog2(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    // Storage and per-channel bookkeeping
    logic [TKT_W-1:0]  r_mem_tkt  [NCH][DEPTH];
    logic [DATA_W-1:0] r_mem_data [NCH][DEPTH];
    logic [PTR_W-1:0]  r_head     [NCH];
    logic [PTR_W-1:0]  r_tail     [NCH];
    logic [CNT_W-1:0]  r_count    [NCH];
    logic [TKT_W-1:0]  r_tkt;
    logic [15:0]       r_drop;

    // Arbiter state
    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic [CH_W-1:0]   r_lock_ch;
`ifndef SVC_QUEUE_STRICT_PRIO_EN
    logic [CH_W-1:0]   r_rr_last;
`endif

    // Combinational helpers
    logic [NCH-1:0]    w_full;
    logic [NCH-1:0]    w_empty;
    logic              w_ch_ok;
    logic              w_sel_full;
    logic              w_accept;
    logic              w_reject;
    logic              w_any;
    logic [CH_W-1:0]   w_pick;
    logic              w_grant_valid;
    logic [CH_W-1:0]   w_grant_ch;
    logic              w_handshake;
    logic [NCH-1:0]    w_push;
    logic [NCH-1:0]    w_pop;
    logic [TKT_W-1:0]  w_head_tkt;
    logic [DATA_W-1:0] w_head_data;

    // Circular pointer advance with wrap at DEPTH-1
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    // Per-channel full/empty from the registered occupancy
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            w_full[k]  = (r_count[k] == CNT_W'(DEPTH));
            w_empty[k] = (r_count[k] == {CNT_W{1'b0}});
        end
    end

    // Enqueue acceptance: channel must exist and not be full. A pop in the
    // same cycle does not free a slot for this cycle's push.
    always_comb begin
        w_ch_ok    = 1'b0;
        w_sel_full = 1'b1;
        for (int k = 0; k < NCH; k++) begin
            w_ch_ok    = w_ch_ok | (enq_ch == CH_W'(k));
            w_sel_full = (enq_ch == CH_W'(k)) ? w_full[k] : w_sel_full;
        end
    end

    assign enq_ready = w_ch_ok && !w_sel_full;
    assign w_accept  = enq_valid && enq_ready;
    assign w_reject  = enq_valid && !enq_ready;
    assign enq_tkt   = r_tkt;

    // Candidate search; scanning downward and overwriting leaves the first
    // non-empty channel in ascending search order.
    always_comb begin
        int w_idx;
        w_any  = 1'b0;
        w_pick = {CH_W{1'b0}};
        w_idx  = 0;
`ifdef SVC_QUEUE_STRICT_PRIO_EN
        for (int i = NCH - 1; i >= 0; i--) begin
            w_any  = w_any | !w_empty[i];
            w_pick = w_empty[i] ? w_pick : CH_W'(i);
        end
`else
        for (int i = NCH; i >= 1; i--) begin
            w_idx  = (int'(r_rr_last) + i) % NCH;
            w_any  = w_any | !w_empty[w_idx];
            w_pick = w_empty[w_idx] ? w_pick : CH_W'(w_idx);
        end
`endif
    end

    // Arbiter state register, lock capture and last-served tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_lock_ch <= {CH_W{1'b0}};
`ifndef SVC_QUEUE_STRICT_PRIO_EN
            r_rr_last <= CH_W'(NCH - 1);
`endif
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && w_state_nxt == ST_LOCKED) begin
                r_lock_ch <= w_grant_ch;
            end
`ifndef SVC_QUEUE_STRICT_PRIO_EN
            if (w_handshake) begin
                r_rr_last <= w_grant_ch;
            end
`endif
        end
    end

    // Arbiter next state: lock when presented but not taken, release on take
    always_comb begin
        case (r_state)
            ST_IDLE:   w_state_nxt = (w_grant_valid && !deq_ready) ? ST_LOCKED : ST_IDLE;
            ST_LOCKED: w_state_nxt = deq_ready ? ST_IDLE : ST_LOCKED;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Arbiter outputs: live search result in IDLE, held grant in LOCKED
    always_comb begin
        case (r_state)
            ST_IDLE: begin
                w_grant_valid = w_any;
                w_grant_ch    = w_pick;
            end
            ST_LOCKED: begin
                w_grant_valid = 1'b1;
                w_grant_ch    = r_lock_ch;
            end
            default: begin
                w_grant_valid = 1'b0;
                w_grant_ch    = {CH_W{1'b0}};
            end
        endcase
    end

    assign w_handshake = w_grant_valid && deq_ready;

    // Head read of the granted channel. Only the grant can pop that channel,
    // so the head stays stable for as long as the lock is held.
    assign w_head_tkt  = r_mem_tkt[w_grant_ch][r_head[w_grant_ch]];
    assign w_head_data = r_mem_data[w_grant_ch][r_head[w_grant_ch]];

    assign deq_valid = w_grant_valid;
    assign deq_ch    = w_grant_valid ? w_grant_ch  : {CH_W{1'b0}};
    assign deq_data  = w_grant_valid ? w_head_data : {DATA_W{1'b0}};
    assign deq_tkt   = w_grant_valid ? w_head_tkt  : {TKT_W{1'b0}};

    // Per-channel push/pop strobes
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            w_push[k] = w_accept && (enq_ch == CH_W'(k));
            w_pop[k]  = w_handshake && (w_grant_ch == CH_W'(k));
        end
    end

    // FIFO storage, pointers, occupancy, ticket and drop counters
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NCH; k++) begin
                for (int d = 0; d < DEPTH; d++) begin
                    r_mem_tkt[k][d]  <= {TKT_W{1'b0}};
                    r_mem_data[k][d] <= {DATA_W{1'b0}};
                end
                r_head[k]  <= {PTR_W{1'b0}};
                r_tail[k]  <= {PTR_W{1'b0}};
                r_count[k] <= {CNT_W{1'b0}};
            end
            r_tkt  <= {TKT_W{1'b0}};
            r_drop <= 16'h0000;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (w_push[k]) begin
                    r_mem_tkt[k][r_tail[k]]  <= r_tkt;
                    r_mem_data[k][r_tail[k]] <= enq_data;
                    r_tail[k]                <= ptr_inc(r_tail[k]);
                end
                if (w_pop[k]) begin
                    r_head[k] <= ptr_inc(r_head[k]);
                end
                case ({w_push[k], w_pop[k]})
                    2'b10:   r_count[k] <= r_count[k] + CNT_W'(1);
                    2'b01:   r_count[k] <= r_count[k] - CNT_W'(1);
                    default: r_count[k] <= r_count[k];
                endcase
            end
            if (w_accept) begin
                r_tkt <= r_tkt + TKT_W'(1);
            end
            if (w_reject && (r_drop != 16'hFFFF)) begin
                r_drop <= r_drop + 16'h0001;
            end
        end
    end

    assign full     = w_full;
    assign empty    = w_empty;
    assign drop_cnt = r_drop;

    genvar gk;
    generate
        for (gk = 0; gk < NCH; gk++) begin : g_count
            assign count[(gk+1)*CNT_W-1 -: CNT_W] = r_count[gk];
        end
    endgenerate

endmodule

// File: tb/tb_svc_queue.sv
// Directed bench for svc_queue (NCH=4, DEPTH=4, DATA_W=8, TKT_W=8).
module tb_svc_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        enq_valid;
    logic [1:0]  enq_ch;
    logic [7:0]  enq_data;
    logic        enq_ready;
    logic [7:0]  enq_tkt;
    logic        deq_valid;
    logic        deq_ready;
    logic [1:0]  deq_ch;
    logic [7:0]  deq_data;
    logic [7:0]  deq_tkt;
    logic [3:0]  full;
    logic [3:0]  empty;
    logic [11:0] count;
    logic [15:0] drop_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    svc_queue dut (
        .clk       (clk),
        .rst       (rst),
        .enq_valid (enq_valid),
        .enq_ch    (enq_ch),
        .enq_data  (enq_data),
        .enq_ready (enq_ready),
        .enq_tkt   (enq_tkt),
        .deq_valid (deq_valid),
        .deq_ready (deq_ready),
        .deq_ch    (deq_ch),
        .deq_data  (deq_data),
        .deq_tkt   (deq_tkt),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .drop_cnt  (drop_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] cnt(input int ch);
        return count[ch*3 +: 3];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single accepted enqueue with ready/ticket checked before the edge
    task automatic enq(input logic [1:0] ch, input logic [7:0] d, input logic [7:0] t);
        enq_valid = 1'b1;
        enq_ch    = ch;
        enq_data  = d;
        #1;
        check("enq_ready", enq_ready, 1);
        check("enq_tkt", enq_tkt, t);
        tick();
        enq_valid = 1'b0;
    endtask

    // Single handshake with the presented entry checked before the edge
    task automatic deq(input logic [1:0] ch, input logic [7:0] d, input logic [7:0] t);
        deq_ready = 1'b1;
        #1;
        check("deq_valid", deq_valid, 1);
        check("deq_ch", deq_ch, ch);
        check("deq_data", deq_data, d);
        check("deq_tkt", deq_tkt, t);
        tick();
        deq_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_t;
        logic [7:0] exp_d;

        rst = 1'b1; enq_valid = 1'b0; enq_ch = 2'd0; enq_data = 8'h00; deq_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_count", count, 0);
        check("rst_empty", empty, 4'hF);
        check("rst_full", full, 0);
        check("rst_deq_valid", deq_valid, 0);
        check("rst_deq_ch", deq_ch, 0);
        check("rst_deq_data", deq_data, 0);
        check("rst_deq_tkt", deq_tkt, 0);
        check("rst_enq_tkt", enq_tkt, 0);
        check("rst_drop", drop_cnt, 0);

        // First entry becomes visible one cycle after the accept edge
        enq(2'd2, 8'h35, 8'd0);
        check("t1_valid", deq_valid, 1);
        check("t1_ch", deq_ch, 2);
        check("t1_data", deq_data, 8'h35);
        check("t1_tkt", deq_tkt, 0);
        check("t1_empty", empty, 4'b1011);
        deq(2'd2, 8'h35, 8'd0);
        check("t1_empty_after", empty, 4'hF);
        check("t1_valid_after", deq_valid, 0);
        check("t1_data_zero", deq_data, 0);

        // Fill ch0, then overflow and same-cycle pop+push on the full channel
        for (int i = 0; i < 4; i++) enq(2'd0, 8'(8'hA0 + i), 8'(1 + i));
        check("t2_count0", cnt(0), 4);
        check("t2_full", full, 4'b0001);
        enq_valid = 1'b1; enq_ch = 2'd0; enq_data = 8'hFF;
        #1;
        check("t2_ready_full", enq_ready, 0);
        tick();
        enq_valid = 1'b0;
        check("t2_drop1", drop_cnt, 1);
        check("t2_count0_kept", cnt(0), 4);
        enq_valid = 1'b1; deq_ready = 1'b1;
        #1;
        check("t2_ready_full_pop", enq_ready, 0);
        check("t2_pop_tkt", deq_tkt, 1);
        check("t2_pop_data", deq_data, 8'hA0);
        tick();
        enq_valid = 1'b0; deq_ready = 1'b0;
        check("t2_drop2", drop_cnt, 2);
        check("t2_count0_pop", cnt(0), 3);
        check("t2_full_clear", full, 0);
        deq(2'd0, 8'hA1, 8'd2);
        deq(2'd0, 8'hA2, 8'd3);
        deq(2'd0, 8'hA3, 8'd4);

        // Reset mid-operation drops entries, lock and ticket count
        enq(2'd1, 8'h55, 8'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("mr_empty", empty, 4'hF);
        check("mr_valid", deq_valid, 0);
        check("mr_enq_tkt", enq_tkt, 0);
        check("mr_count1", cnt(1), 0);

        // One entry per channel, served back-to-back in channel order
        for (int c = 0; c < 4; c++) enq(2'(c), 8'(8'h10 + c), 8'(c));
        for (int c = 0; c < 4; c++) deq(2'(c), 8'(8'h10 + c), 8'(c));
        check("t3_drained", deq_valid, 0);
        enq(2'd1, 8'h61, 8'd4);
        enq(2'd3, 8'h63, 8'd5);
        deq(2'd1, 8'h61, 8'd4);
        deq(2'd3, 8'h63, 8'd5);

        // Locked grant holds ch1 even though ch0 would otherwise win
        enq(2'd1, 8'h71, 8'd6);
        tick();
        check("t4_hold_a", deq_ch, 1);
        enq(2'd0, 8'h70, 8'd7);
        check("t4_hold_b", deq_ch, 1);
        check("t4_hold_tkt", deq_tkt, 6);
        check("t4_empty", empty, 4'b1100);
        deq(2'd1, 8'h71, 8'd6);
        deq(2'd0, 8'h70, 8'd7);

        // 260 push/pop pairs on ch0: ticket wrap and pointer wrap
        exp_t = 8'd8;
        exp_d = 8'd0;
        enq_valid = 1'b1;
        enq_ch    = 2'd0;
        for (int i = 0; i < 260; i++) begin
            enq_data  = 8'(i);
            deq_ready = (i != 0);
            #1;
            check("t5_ready", enq_ready, 1);
            if (i != 0) begin
                check("t5_valid", deq_valid, 1);
                check("t5_tkt", deq_tkt, exp_t);
                check("t5_data", deq_data, exp_d);
                check("t5_count", cnt(0), 1);
                exp_t = exp_t + 8'd1;
                exp_d = exp_d + 8'd1;
            end
            tick();
        end
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        deq(2'd0, 8'd3, 8'd11);
        check("t5_empty", empty, 4'hF);

        // ch0 and ch3 both backlogged
        rst = 1'b1;
        tick();
        rst = 1'b0;
        enq(2'd0, 8'h00, 8'd0);
        enq(2'd0, 8'h01, 8'd1);
        enq(2'd3, 8'h30, 8'd2);
        enq(2'd3, 8'h31, 8'd3);
`ifdef SVC_QUEUE_STRICT_PRIO_EN
        deq(2'd0, 8'h00, 8'd0);
        deq(2'd0, 8'h01, 8'd1);
        deq(2'd3, 8'h30, 8'd2);
        deq(2'd3, 8'h31, 8'd3);
`else
        deq(2'd0, 8'h00, 8'd0);
        deq(2'd3, 8'h30, 8'd2);
        deq(2'd0, 8'h01, 8'd1);
        deq(2'd3, 8'h31, 8'd3);
`endif
        check("t6_empty", empty, 4'hF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
